// File: rtl/instr_streamer.sv
// instr_streamer
// Transmit end of the host command protocol. One decoded command is taken
// per cmd_valid/cmd_ready handshake. It is packed into the 16-bit
// instruction word that the on-chip controller decodes, then streamed out
// as little-endian bytes on a valid/ready byte port.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. A producer holds valid and its payload stable until that edge,
// and never withdraws valid without a transfer (reset excepted).
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous, active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_opcode     0 STORE, 1 FETCH, 2 RUN, 3 LOAD, 4 HALT, 5 NOP (6, 7 illegal)
//   cmd_flags      copied to instruction bits [5:3]
//   cmd_addr       address field for FETCH/RUN/LOAD
//   cmd_store_addr STORE target address
//   cmd_store_val  STORE value; sent only when cmd_flags[1]=1
//   byte_valid/byte_ready/byte_data   output byte stream
//   busy           a command is being sent
//   halted         HALT has been sent completely; terminal until reset
//   err            one-cycle pulse after an illegal opcode is accepted
//   dbg_state      current FSM state, for observation
module instr_streamer #(
    parameter int OPCODE_WIDTH     = 3,
    parameter int BUFFER_WORD_SIZE = 16,
    parameter int FIFO_DATA_WIDTH  = 8,
    parameter int ADDRESS_SIZE     = 9
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [OPCODE_WIDTH-1:0]     cmd_opcode,
    input  logic [2:0]                  cmd_flags,
    input  logic [ADDRESS_SIZE-1:0]     cmd_addr,
    input  logic [ADDRESS_SIZE-1:0]     cmd_store_addr,
    input  logic [BUFFER_WORD_SIZE-1:0] cmd_store_val,
    output logic                        byte_valid,
    input  logic                        byte_ready,
    output logic [FIFO_DATA_WIDTH-1:0]  byte_data,
    output logic                        busy,
    output logic                        halted,
    output logic                        err,
    output logic [2:0]                  dbg_state
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] INSTR_LO = 3'd1;
    localparam logic [2:0] INSTR_HI = 3'd2;
    localparam logic [2:0] ADDR_LO  = 3'd3;
    localparam logic [2:0] ADDR_HI  = 3'd4;
    localparam logic [2:0] VAL_LO   = 3'd5;
    localparam logic [2:0] VAL_HI   = 3'd6;
    localparam logic [2:0] HALTED   = 3'd7;

    localparam logic [OPCODE_WIDTH-1:0] OP_STORE = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_FETCH = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_RUN   = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_HALT  = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = OPCODE_WIDTH'(5);

    logic [2:0]                  state;
    logic [BUFFER_WORD_SIZE-1:0] instr_q;
    logic [BUFFER_WORD_SIZE-1:0] addr_q;
    logic [BUFFER_WORD_SIZE-1:0] val_q;
    logic                        store_q;
    logic                        has_val_q;
    logic                        halt_q;

    logic                        accept;
    logic                        take;
    logic                        legal;
    logic [BUFFER_WORD_SIZE-1:0] instr_next;

    assign cmd_ready  = (state == IDLE) && rst;
    assign accept     = cmd_valid && cmd_ready;
    assign byte_valid = (state != IDLE) && (state != HALTED);
    assign take       = byte_valid && byte_ready;
    assign busy       = byte_valid;
    assign halted     = (state == HALTED);
    assign dbg_state  = state;
    assign legal      = (cmd_opcode <= OP_NOP);

    // Instruction word packing; an illegal opcode collapses to a bare NOP.
    always_comb begin
        instr_next = '0;
        if (legal) begin
            instr_next[OPCODE_WIDTH-1:0] = cmd_opcode;
            instr_next[5:3]              = cmd_flags;
            if ((cmd_opcode == OP_FETCH) || (cmd_opcode == OP_RUN) ||
                (cmd_opcode == OP_LOAD)) begin
                instr_next[BUFFER_WORD_SIZE-1 -: ADDRESS_SIZE] = cmd_addr;
            end
        end else begin
            instr_next[OPCODE_WIDTH-1:0] = OP_NOP;
        end
    end

    // Output byte is a pure function of state and the captured words, so it
    // stays stable for as long as the state is held by backpressure.
    always_comb begin
        byte_data = '0;
        case (state)
            INSTR_LO: byte_data = instr_q[FIFO_DATA_WIDTH-1:0];
            INSTR_HI: byte_data = instr_q[BUFFER_WORD_SIZE-1:FIFO_DATA_WIDTH];
            ADDR_LO:  byte_data = addr_q[FIFO_DATA_WIDTH-1:0];
            ADDR_HI:  byte_data = addr_q[BUFFER_WORD_SIZE-1:FIFO_DATA_WIDTH];
            VAL_LO:   byte_data = val_q[FIFO_DATA_WIDTH-1:0];
            VAL_HI:   byte_data = val_q[BUFFER_WORD_SIZE-1:FIFO_DATA_WIDTH];
            default:  byte_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            instr_q   <= '0;
            addr_q    <= '0;
            val_q     <= '0;
            store_q   <= 1'b0;
            has_val_q <= 1'b0;
            halt_q    <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= accept && !legal;
            case (state)
                IDLE: begin
                    if (accept) begin
                        instr_q   <= instr_next;
                        addr_q    <= {{(BUFFER_WORD_SIZE-ADDRESS_SIZE){1'b0}}, cmd_store_addr};
                        val_q     <= cmd_store_val;
                        store_q   <= (cmd_opcode == OP_STORE);
                        has_val_q <= cmd_flags[1];
                        halt_q    <= (cmd_opcode == OP_HALT);
                        state     <= INSTR_LO;
                    end
                end
                INSTR_LO: if (take) state <= INSTR_HI;
                INSTR_HI: begin
                    if (take) begin
                        if (store_q)     state <= ADDR_LO;
                        else if (halt_q) state <= HALTED;
                        else             state <= IDLE;
                    end
                end
                ADDR_LO: if (take) state <= ADDR_HI;
                ADDR_HI: begin
                    if (take) state <= has_val_q ? VAL_LO : IDLE;
                end
                VAL_LO: if (take) state <= VAL_HI;
                VAL_HI: if (take) state <= IDLE;
                default: state <= HALTED;   // HALTED holds until reset
            endcase
        end
    end

endmodule

// File: tb/tb_instr_streamer.sv
module tb_instr_streamer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_opcode;
  logic [2:0]  cmd_flags;
  logic [8:0]  cmd_addr;
  logic [8:0]  cmd_store_addr;
  logic [15:0] cmd_store_val;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;
  logic        busy;
  logic        halted;
  logic        err;
  logic [2:0]  dbg_state;

  logic [7:0]  exp_q[$];
  int          n_checks;
  int          n_fail;
  logic        rnd_ready;
  logic        hold;
  logic [7:0]  held_data;

  instr_streamer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_flags(cmd_flags), .cmd_addr(cmd_addr),
    .cmd_store_addr(cmd_store_addr), .cmd_store_val(cmd_store_val),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .busy(busy), .halted(halted), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // random byte_ready driver, enabled per test
  always @(posedge clk) begin
    #1;
    if (rnd_ready) byte_ready = 1'($urandom_range(0, 1));
  end

  // scoreboard monitor: stability under backpressure and byte order
  always @(negedge clk) begin
    if (!rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", 32'(byte_valid), 32'd1);
        check("hold_data", 32'(byte_data), 32'(held_data));
      end
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%0h expected none at %0t", byte_data, $time);
        end else begin
          check("byte", 32'(byte_data), 32'(exp_q.pop_front()));
        end
        hold = 1'b0;
      end else if (byte_valid) begin
        hold = 1'b1;
        held_data = byte_data;
      end else begin
        hold = 1'b0;
      end
    end
  end

  // driver: offer a command and return just after the accepting edge
  task automatic send(input logic [2:0] op, input logic [2:0] fl, input logic [8:0] ad,
                      input logic [8:0] sa, input logic [15:0] sv);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    cmd_opcode = op; cmd_flags = fl; cmd_addr = ad;
    cmd_store_addr = sa; cmd_store_val = sv;
    cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: got no acceptance expected acceptance at %0t", $time);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_opcode = 3'h6; cmd_flags = 3'h7; cmd_addr = 9'h1FF;
    cmd_store_addr = 9'h1FF; cmd_store_val = 16'hFFFF;
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL %s_drain: got %0d bytes pending expected 0", name, exp_q.size());
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; rnd_ready = 1'b0; hold = 1'b0; held_data = '0;
    rst = 1'b0; cmd_valid = 1'b0; byte_ready = 1'b1;
    cmd_opcode = '0; cmd_flags = '0; cmd_addr = '0; cmd_store_addr = '0; cmd_store_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_byte_valid", 32'(byte_valid), 32'd0);
    check("rst_byte_data", 32'(byte_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // RUN flags 111 addr 1A5: word 0xD2BA, exact timing
    exp_q.push_back(8'hBA); exp_q.push_back(8'hD2);
    send(3'd2, 3'b111, 9'h1A5, 9'h000, 16'h0000);
    @(negedge clk);
    check("run_n1_valid", 32'(byte_valid), 32'd1);
    check("run_n1_busy", 32'(busy), 32'd1);
    check("run_n1_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("run_n2_valid", 32'(byte_valid), 32'd1);
    check("run_n2_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("run_n3_ready", 32'(cmd_ready), 32'd1);
    check("run_n3_busy", 32'(busy), 32'd0);
    check("run_n3_valid", 32'(byte_valid), 32'd0);
    check("run_pending", 32'(exp_q.size()), 32'd0);

    // STORE with value: 6 bytes back to back, ready again after 7 cycles
    exp_q.push_back(8'h10); exp_q.push_back(8'h00);
    exp_q.push_back(8'h23); exp_q.push_back(8'h01);
    exp_q.push_back(8'hEF); exp_q.push_back(8'hBE);
    send(3'd0, 3'b010, 9'h1A5, 9'h123, 16'hBEEF);
    repeat (6) @(negedge clk);
    check("store_val_n6_valid", 32'(byte_valid), 32'd1);
    @(negedge clk);
    check("store_val_n7_ready", 32'(cmd_ready), 32'd1);
    check("store_val_pending", 32'(exp_q.size()), 32'd0);

    // STORE without value
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    send(3'd0, 3'b000, 9'h1A5, 9'h0FF, 16'h1234);
    wait_drain("store_noval");
    check("store_noval_idle", 32'(dbg_state), 32'd0);

    // FETCH under random backpressure
    exp_q.push_back(8'h89); exp_q.push_back(8'h01);
    rnd_ready = 1'b1;
    send(3'd1, 3'b001, 9'h003, 9'h000, 16'h0000);
    wait_drain("fetch");
    rnd_ready = 1'b0;
    @(posedge clk); #1;
    byte_ready = 1'b1;

    // illegal opcode 7
    exp_q.push_back(8'h05); exp_q.push_back(8'h00);
    send(3'd7, 3'b111, 9'h1FF, 9'h1FF, 16'hFFFF);
    @(negedge clk);
    check("err_pulse", 32'(err), 32'd1);
    @(negedge clk);
    check("err_clear", 32'(err), 32'd0);
    wait_drain("illegal");

    // HALT, then further commands are refused
    exp_q.push_back(8'h04); exp_q.push_back(8'h00);
    send(3'd4, 3'b000, 9'h1FF, 9'h000, 16'h0000);
    @(negedge clk);
    check("halt_n1_halted", 32'(halted), 32'd0);
    @(negedge clk);
    check("halt_n2_halted", 32'(halted), 32'd0);
    @(negedge clk);
    check("halt_n3_halted", 32'(halted), 32'd1);
    check("halt_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_opcode = 3'd5;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("halted_cmd_ready", 32'(cmd_ready), 32'd0);
      check("halted_valid", 32'(byte_valid), 32'd0);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;

    // reset out of HALTED
    rst = 1'b0;
    @(negedge clk);
    check("rst2_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst2_halted", 32'(halted), 32'd0);

    // LOAD interrupted by reset before its low byte is taken
    byte_ready = 1'b0;
    send(3'd3, 3'b000, 9'h010, 9'h000, 16'h0000);
    @(negedge clk);
    check("load_lo_valid", 32'(byte_valid), 32'd1);
    check("load_lo_data", 32'(byte_data), 32'h03);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_valid", 32'(byte_valid), 32'd0);
    check("midrst_data", 32'(byte_data), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_halted", 32'(halted), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    byte_ready = 1'b1;

    // NOP after reset: only its own two bytes
    exp_q.push_back(8'h05); exp_q.push_back(8'h00);
    send(3'd5, 3'b000, 9'h1FF, 9'h000, 16'h0000);
    wait_drain("nop");
    repeat (4) @(negedge clk);
    check("final_pending", 32'(exp_q.size()), 32'd0);
    check("final_idle", 32'(dbg_state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
